l1_mem_arbiter: RTL and testbench

- Sits directly downstream of the two L1 caches (I-side, D-side) and services their 256-bit line refill and writeback requests against one single-port line RAM.
- Arbitrates round-robin between the two caches.
- Sequences the RAM's fixed read latency and returns one-cycle done pulses on each cache's MMU-side handshake.

---
 rtl/l1_mem_arbiter_if.sv | 39 +++
 rtl/l1_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_l1_mem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_mem_arbiter_if.sv
// Cache-side and RAM-side bus of the L1 memory arbiter.
// Handshake: each cache holds its request level until it sees a one-cycle done pulse; read data is valid in that cycle.
interface l1_mem_arbiter_if #(
   parameter int LINE_W = 256,
   parameter int IDX_W  = 12
);
   logic              i_req_read;
   logic [31:0]       i_req_addr;
   logic              i_read_done;
   logic [LINE_W-1:0] i_read_data;
   logic              d_req_read;
   logic              d_req_write;
   logic [31:0]       d_req_addr;
   logic [LINE_W-1:0] d_write_data;
   logic              d_read_done;
   logic              d_write_done;
   logic [LINE_W-1:0] d_read_data;
   logic              ram_en;
   logic              ram_we;
   logic [IDX_W-1:0]  ram_addr;
   logic [LINE_W-1:0] ram_din;
   logic [LINE_W-1:0] ram_dout;

   // Arbiter side.
   modport slave (
      input  i_req_read, i_req_addr, d_req_read, d_req_write, d_req_addr,
             d_write_data, ram_dout,
      output i_read_done, i_read_data, d_read_done, d_write_done, d_read_data,
             ram_en, ram_we, ram_addr, ram_din
   );

   // Cache and RAM side.
   modport master (
      output i_req_read, i_req_addr, d_req_read, d_req_write, d_req_addr,
             d_write_data, ram_dout,
      input  i_read_done, i_read_data, d_read_done, d_write_done, d_read_data,
             ram_en, ram_we, ram_addr, ram_din
   );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter between the I- and D-cache line requests onto one single-port line RAM.
// Reads wait out the fixed RAM latency; every transaction ends with a DONE cycle carrying the done pulse.
module l1_mem_arbiter #(
   parameter int LINE_W  = 256,
   parameter int IDX_W   = 12,
   parameter int RAM_LAT = 2
) (
   input  logic            sys_clk,
   input  logic            rst_n,
   l1_mem_arbiter_if.slave bus,
   output logic [1:0]      state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR      = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [2:0] CNT_INIT = 3'(RAM_LAT - 1);

   state_t            state_q;
   state_t            state_d;
   logic [2:0]        cnt_q;
   logic              gnt_d_q;
   logic              gnt_wr_q;
   logic [IDX_W-1:0]  idx_q;
   logic [LINE_W-1:0] wdata_q;
   logic              last_d_q;
   logic [LINE_W-1:0] i_rd_q;
   logic [LINE_W-1:0] d_rd_q;

   logic              i_pend;
   logic              d_pend;
   logic              pick_d;
   logic              grant;
   logic              grant_wr;
   logic [IDX_W-1:0]  grant_idx;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{bus.i_req_addr[31:IDX_W+5], bus.i_req_addr[4:0],
                               bus.d_req_addr[31:IDX_W+5], bus.d_req_addr[4:0]};

   // On a tie the client that was not served last wins; last_d_q resets to I so D takes the first tie.
   always_comb begin
      i_pend    = bus.i_req_read;
      d_pend    = bus.d_req_read | bus.d_req_write;
      pick_d    = d_pend && (!i_pend || !last_d_q);
      grant     = rst_n && (state_q == IDLE) && (i_pend || d_pend);
      grant_wr  = pick_d && bus.d_req_write;
      grant_idx = pick_d ? bus.d_req_addr[IDX_W+4:5] : bus.i_req_addr[IDX_W+4:5];
   end

   // State register.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant) state_d = grant_wr ? WR : RD_WAIT;
         RD_WAIT: if (cnt_q == 3'd0) state_d = DONE;
         WR:      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transaction latches, latency counter and per-client read data.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         cnt_q    <= 3'd0;
         gnt_d_q  <= 1'b0;
         gnt_wr_q <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         last_d_q <= 1'b0;
         i_rd_q   <= '0;
         d_rd_q   <= '0;
      end else begin
         if (grant) begin
            gnt_d_q  <= pick_d;
            gnt_wr_q <= grant_wr;
            idx_q    <= grant_idx;
            last_d_q <= pick_d;
            cnt_q    <= CNT_INIT;
            if (grant_wr) wdata_q <= bus.d_write_data;
         end
         if (state_q == RD_WAIT) begin
            if (cnt_q == 3'd0) begin
               if (gnt_d_q) d_rd_q <= bus.ram_dout;
               else         i_rd_q <= bus.ram_dout;
            end else begin
               cnt_q <= cnt_q - 3'd1;
            end
         end
      end
   end

   // Outputs: read enable only in the grant cycle, write enable only in WR, done only in DONE.
   always_comb begin
      bus.ram_en       = (grant && !grant_wr) || (state_q == WR);
      bus.ram_we       = (state_q == WR);
      bus.ram_addr     = '0;
      bus.ram_din      = '0;
      if (state_q == WR) begin
         bus.ram_addr = idx_q;
         bus.ram_din  = wdata_q;
      end else if (grant) begin
         bus.ram_addr = grant_idx;
      end
      bus.i_read_done  = (state_q == DONE) && !gnt_d_q && !gnt_wr_q;
      bus.d_read_done  = (state_q == DONE) && gnt_d_q && !gnt_wr_q;
      bus.d_write_done = (state_q == DONE) && gnt_wr_q;
      bus.i_read_data  = i_rd_q;
      bus.d_read_data  = d_rd_q;
      state_dbg        = state_q;
   end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomised scoreboard bench for l1_mem_arbiter: a transaction-level model predicts grant order and
// returned lines; a monitor pops the expected queue on every done pulse.
module tb_l1_mem_arbiter #(
   parameter int RAM_LAT = 2
);
   localparam int LINE_W = 256;
   localparam int IDX_W  = 12;
   localparam int SB_W   = LINE_W + 2;
   localparam int K_IRD  = 0;
   localparam int K_DRD  = 1;
   localparam int K_DWR  = 2;

   logic       sys_clk;
   logic       rst_n;
   logic [1:0] state_dbg;

   l1_mem_arbiter_if #(.LINE_W(LINE_W), .IDX_W(IDX_W)) bus ();

   l1_mem_arbiter #(.LINE_W(LINE_W), .IDX_W(IDX_W), .RAM_LAT(RAM_LAT)) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- checking counters and helpers ----------------
   int errors = 0;
   int checks = 0;
   bit mon_en = 0;

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic chk_line(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [LINE_W-1:0] init_line(input int i);
      logic [LINE_W-1:0] v;
      for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = 32'(i) * 32'h9E37_79B1 + 32'(w);
      return v;
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] v;
      for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = $urandom();
      return v;
   endfunction

   // ---------------- RAM model (environment) ----------------
   logic [LINE_W-1:0] mem [1<<IDX_W];
   logic [LINE_W-1:0] rd_pipe [RAM_LAT];
   bit                mem_ready = 0;
   bit                pre_en = 0;
   logic [IDX_W-1:0]  pre_idx = '0;
   logic [LINE_W-1:0] pre_data = '0;

   always @(posedge sys_clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < (1 << IDX_W); i++) mem[i] <= init_line(i);
         mem_ready <= 1'b1;
      end else if (pre_en) begin
         mem[pre_idx] <= pre_data;
      end else if (bus.ram_en && bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_din;
      end
      // Junk outside the valid slot exposes a capture at the wrong cycle.
      rd_pipe[0] <= (bus.ram_en && !bus.ram_we) ? mem[bus.ram_addr] : rand_line();
      for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.ram_dout = rd_pipe[RAM_LAT-1];

   always @(posedge sys_clk)
      assert (!(bus.d_req_read && bus.d_req_write)) else $error("protocol error: d read and write both high");

   // ---------------- reference model and scoreboard ----------------
   logic [SB_W-1:0]   exp_q [$];
   logic [LINE_W-1:0] shadow [int];
   bit                lg_d = 0;

   function automatic int line_idx(input logic [31:0] a);
      return int'((a >> 5) % (32'd1 << IDX_W));
   endfunction

   function automatic logic [LINE_W-1:0] model_read(input int idx);
      return shadow.exists(idx) ? shadow[idx] : init_line(idx);
   endfunction

   task automatic model_issue(input int kind, input logic [31:0] addr, input logic [LINE_W-1:0] wdata);
      int idx;
      idx = line_idx(addr);
      if (kind == K_DWR) begin
         shadow[idx] = wdata;
         exp_q.push_back({2'(kind), wdata});
      end else begin
         exp_q.push_back({2'(kind), model_read(idx)});
      end
      lg_d = (kind != K_IRD);
   endtask

   // Monitor: pops one expected response per done pulse; also checks pulse-shape invariants.
   initial begin
      int nd;
      int akind;
      int ekind;
      bit prev_done;
      logic [SB_W-1:0] item;
      prev_done = 0;
      forever begin
         @(negedge sys_clk);
         if (mon_en) begin
            nd = int'(bus.i_read_done) + int'(bus.d_read_done) + int'(bus.d_write_done);
            chk32("one_done_per_cycle", 32'(nd <= 1), 32'd1);
            chk32("no_back_to_back_done", 32'(prev_done && nd > 0), 32'd0);
            chk32("we_only_in_wr", 32'(bus.ram_we && state_dbg != 2'd2), 32'd0);
            prev_done = (nd > 0);
            if (nd == 1) begin
               akind = bus.i_read_done ? K_IRD : (bus.d_read_done ? K_DRD : K_DWR);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done kind=%0d with empty queue (cycle %0d)", akind, cyc);
               end else begin
                  item  = exp_q.pop_front();
                  ekind = int'(item[SB_W-1 -: 2]);
                  chk32("done_kind_order", 32'(akind), 32'(ekind));
                  if (akind == K_IRD) chk_line("i_read_data", bus.i_read_data, item[LINE_W-1:0]);
                  if (akind == K_DRD) chk_line("d_read_data", bus.d_read_data, item[LINE_W-1:0]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic i_read(input logic [31:0] addr, output int lat);
      int start;
      bit ok;
      ok = 0;
      @(posedge sys_clk); #1;
      bus.i_req_addr = addr;
      bus.i_req_read = 1'b1;
      start = cyc;
      for (int k = 0; k < 100; k++) begin
         @(negedge sys_clk);
         if (bus.i_read_done) begin ok = 1; break; end
      end
      lat = cyc - start;
      chk32("i_read_done_timeout", 32'(ok), 32'd1);
      @(posedge sys_clk); #1;
      bus.i_req_read = 1'b0;
   endtask

   task automatic d_op(input bit wr, input logic [31:0] addr, input logic [LINE_W-1:0] data, output int lat);
      int start;
      bit ok;
      ok = 0;
      @(posedge sys_clk); #1;
      bus.d_req_addr   = addr;
      bus.d_write_data = data;
      bus.d_req_write  = wr;
      bus.d_req_read   = !wr;
      start = cyc;
      for (int k = 0; k < 100; k++) begin
         @(negedge sys_clk);
         if (bus.d_read_done || bus.d_write_done) begin ok = 1; break; end
      end
      lat = cyc - start;
      chk32("d_done_timeout", 32'(ok), 32'd1);
      @(posedge sys_clk); #1;
      bus.d_req_write = 1'b0;
      bus.d_req_read  = 1'b0;
   endtask

   // Both caches raise in the same cycle; the model decides who is served first.
   task automatic issue_pair(input logic [31:0] ia, input bit dwr, input logic [31:0] da,
                             input logic [LINE_W-1:0] dd);
      int li;
      int ld;
      if (!lg_d) begin
         model_issue(dwr ? K_DWR : K_DRD, da, dd);
         model_issue(K_IRD, ia, '0);
      end else begin
         model_issue(K_IRD, ia, '0);
         model_issue(dwr ? K_DWR : K_DRD, da, dd);
      end
      fork
         i_read(ia, li);
         d_op(dwr, da, dd, ld);
      join
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom();
      a[IDX_W+4:5] = IDX_W'($urandom_range(0, 7));
      return a;
   endfunction

   // ---------------- main sequence ----------------
   localparam logic [LINE_W-1:0] A5_LINE = {32{8'hA5}};
   localparam logic [LINE_W-1:0] EF_LINE = {8{32'hEEEE_FFFF}};

   initial begin
      int lat;
      int mode;
      bit found;
      logic [31:0] a;
      logic [31:0] b;

      bus.i_req_read = 0; bus.i_req_addr = '0;
      bus.d_req_read = 0; bus.d_req_write = 0; bus.d_req_addr = '0; bus.d_write_data = '0;

      // Reset then idle.
      rst_n = 1'b0;
      repeat (4) @(posedge sys_clk);
      @(negedge sys_clk);
      chk32("rst_state", 32'(state_dbg), 32'd0);
      chk32("rst_ctrl", {27'd0, bus.ram_en, bus.ram_we, bus.i_read_done, bus.d_read_done, bus.d_write_done}, 32'd0);
      chk32("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk_line("rst_ram_din", bus.ram_din, '0);
      chk_line("rst_i_data", bus.i_read_data, '0);
      chk_line("rst_d_data", bus.d_read_data, '0);
      @(posedge sys_clk); #1;
      rst_n = 1'b1;
      mon_en = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge sys_clk);
         chk32("idle_ram_en", 32'(bus.ram_en), 32'd0);
      end

      // I read alone of a preloaded line.
      @(posedge sys_clk); #1;
      pre_en = 1; pre_idx = IDX_W'(3); pre_data = A5_LINE;
      @(posedge sys_clk); #1;
      pre_en = 0;
      shadow[3] = A5_LINE;
      model_issue(K_IRD, 32'h0000_006C, '0);
      fork
         i_read(32'h0000_006C, lat);
         begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            chk32("i_grant_ram", {29'd0, bus.ram_en, bus.ram_we, 1'b0}, 32'd4);
            chk32("i_grant_addr", 32'(bus.ram_addr), 32'd3);
            @(negedge sys_clk);
            chk32("i_grant_one_cycle", 32'(bus.ram_en), 32'd0);
         end
      join
      chk32("i_read_latency", 32'(lat), 32'(RAM_LAT + 1));
      repeat (3) @(negedge sys_clk);
      chk_line("i_data_held", bus.i_read_data, A5_LINE);

      // D writeback then read-back.
      model_issue(K_DWR, 32'h0000_4000, EF_LINE);
      fork
         d_op(1'b1, 32'h0000_4000, EF_LINE, lat);
         begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            chk32("wr_grant_no_en", 32'(bus.ram_en), 32'd0);
            @(negedge sys_clk);
            chk32("wr_ram_ctrl", {30'd0, bus.ram_en, bus.ram_we}, 32'd3);
            chk32("wr_ram_addr", 32'(bus.ram_addr), 32'h200);
            chk_line("wr_ram_din", bus.ram_din, EF_LINE);
         end
      join
      chk32("write_latency", 32'(lat), 32'd2);
      model_issue(K_DRD, 32'h0000_4000, '0);
      d_op(1'b0, 32'h0000_4000, '0, lat);
      chk32("d_read_latency", 32'(lat), 32'(RAM_LAT + 1));
      chk_line("i_data_untouched_by_d", bus.i_read_data, A5_LINE);

      // Reset in the middle of a read: no done, back to IDLE, last grant back to I.
      @(posedge sys_clk); #1;
      bus.i_req_addr = 32'h0000_0060;
      bus.i_req_read = 1'b1;
      found = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge sys_clk);
         if (state_dbg == 2'd1) begin found = 1; break; end
      end
      chk32("reached_rd_wait", 32'(found), 32'd1);
      #1;
      rst_n = 1'b0;
      bus.i_req_read = 1'b0;
      @(posedge sys_clk); #1;
      rst_n = 1'b1;
      lg_d = 0;
      @(negedge sys_clk);
      chk32("mid_reset_idle", 32'(state_dbg), 32'd0);
      chk32("mid_reset_we", 32'(bus.ram_we), 32'd0);
      repeat (4) @(negedge sys_clk);
      model_issue(K_IRD, 32'h0000_0060, '0);
      i_read(32'h0000_0060, lat);
      chk32("post_reset_latency", 32'(lat), 32'(RAM_LAT + 1));

      // Contention: both raise together each round.
      for (int r = 0; r < 4; r++) begin
         a = rand_addr();
         b = rand_addr();
         issue_pair(a, 1'b0, b, '0);
      end

      // Randomised traffic.
      for (int r = 0; r < 40; r++) begin
         mode = $urandom_range(0, 4);
         a = rand_addr();
         b = rand_addr();
         case (mode)
            0: begin
               model_issue(K_IRD, a, '0);
               i_read(a, lat);
               chk32("rnd_i_latency", 32'(lat), 32'(RAM_LAT + 1));
            end
            1: begin
               model_issue(K_DRD, b, '0);
               d_op(1'b0, b, '0, lat);
               chk32("rnd_d_latency", 32'(lat), 32'(RAM_LAT + 1));
            end
            2: begin
               logic [LINE_W-1:0] wd;
               wd = rand_line();
               model_issue(K_DWR, b, wd);
               d_op(1'b1, b, wd, lat);
               chk32("rnd_w_latency", 32'(lat), 32'd2);
            end
            3: issue_pair(a, 1'b0, b, '0);
            default: issue_pair(a, 1'b1, b, rand_line());
         endcase
      end

      repeat (5) @(negedge sys_clk);
      chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
